// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit
//
// Purpose:
//   Execute-stage RV32M multiply/divide unit. Accepts one op from the MDU
//   reservation station when idle, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/
//   REM/REMU and holds the result on mdu_result until the CDB arbiter grants
//   it. Single entry, not pipelined: a new op is taken only in IDLE.
//
//   Multiply: one (XLEN+1)x(XLEN+1) signed product, registered through
//   MUL_STAGES stages before landing in the result register.
//   Divide:   radix-2 restoring on operand magnitudes, one quotient bit per
//   cycle, sign fix-up applied when the result is registered.
//   Divide-by-zero and signed overflow are resolved in the accept cycle.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   flush       in   kills the in-flight op and any held result
//   mdu_packet  in   issued op (valid, rs1, rs2, dest tag, funct3)
//   mdu_rdy     out  unit can accept an op this cycle (IDLE only)
//   mdu_result  out  held writeback packet (valid, dest tag, data)
//   cdb_grant   in   CDB arbiter takes mdu_result this cycle
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int MDU_XLEN  = 32;
    localparam int MDU_TAG_W = 6;

    typedef struct packed {
        logic                 valid;
        logic [MDU_TAG_W-1:0] tag;
        logic [2:0]           funct3;
        logic [MDU_XLEN-1:0]  rs1;
        logic [MDU_XLEN-1:0]  rs2;
    } instruction_t;

    typedef struct packed {
        logic                 valid;
        logic [MDU_TAG_W-1:0] tag;
        logic [MDU_XLEN-1:0]  data;
    } writeback_packet_t;

endpackage

module mdu_unit #(
    parameter int XLEN       = mdu_pkg::MDU_XLEN,
    parameter int MUL_STAGES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  mdu_pkg::instruction_t      mdu_packet,
    output logic                       mdu_rdy,
    output mdu_pkg::writeback_packet_t mdu_result,
    input  logic                       cdb_grant
);

    localparam int TAG_W = mdu_pkg::MDU_TAG_W;
    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    // Two's-complement negate when requested (used for magnitudes and the
    // final quotient/remainder sign fix-up).
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                 input logic            neg);
        return neg ? (-v) : v;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q;
    logic             rdy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       f3_q;          // funct3[1:0]; funct3[2] only steers the FSM
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic [XLEN-1:0]  div_rem_q;
    logic [XLEN-1:0]  div_quo_q;     // holds the dividend magnitude, shifted out MSB first
    logic [XLEN-1:0]  div_dvs_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             res_valid_q;
    logic [TAG_W-1:0] res_tag_q;
    logic [XLEN-1:0]  res_data_q;

    // -------------------------------------------------------------------------
    // Accept-cycle decode and special-case resolution
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [2:0]      in_f3;
    logic            in_signed;
    logic            in_a_neg;
    logic            in_b_neg;
    logic            in_div_zero;
    logic            in_div_ovf;
    logic            in_special;
    logic [XLEN-1:0] in_special_res;

    always_comb begin
        in_a        = mdu_packet.rs1;
        in_b        = mdu_packet.rs2;
        in_f3       = mdu_packet.funct3;
        // For divides funct3[0]=1 selects the unsigned flavour.
        in_signed   = ~in_f3[0];
        in_a_neg    = in_signed & in_a[XLEN-1];
        in_b_neg    = in_signed & in_b[XLEN-1];
        in_div_zero = (in_b == '0);
        in_div_ovf  = in_signed && (in_a == MIN_NEG) && (in_b == '1);
        in_special  = in_div_zero | in_div_ovf;
        if (in_f3[1]) begin
            in_special_res = in_div_zero ? in_a : '0;
        end else begin
            in_special_res = in_div_zero ? '1 : in_a;
        end
    end

    // -------------------------------------------------------------------------
    // Multiplier: rs1 is signed for MULH/MULHSU, rs2 only for MULH. The low
    // half is extension-independent, so MUL shares the same product.
    // -------------------------------------------------------------------------
    logic signed [XLEN:0]     mul_a_ext;
    logic signed [XLEN:0]     mul_b_ext;
    logic signed [2*XLEN-1:0] mul_prod;
    logic [2*XLEN-1:0]        mul_tap;
    logic [XLEN-1:0]          mul_res;

    always_comb begin
        mul_a_ext = {(f3_q != 2'b11) & a_q[XLEN-1], a_q};
        mul_b_ext = {(f3_q == 2'b01) & b_q[XLEN-1], b_q};
        // Bits above 2*XLEN never matter for either half, so truncate early.
        mul_prod  = (2*XLEN)'(mul_a_ext) * (2*XLEN)'(mul_b_ext);
    end

    // Extra stages run freely: operands stay put for the whole MUL state,
    // so the tap is correct once the counter expires.
    if (MUL_STAGES > 1) begin : g_mul_pipe
        logic [2*XLEN-1:0] pipe_q [MUL_STAGES-1];
        always_ff @(posedge clk) begin
            pipe_q[0] <= mul_prod;
            for (int i = 1; i < MUL_STAGES - 1; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign mul_tap = pipe_q[MUL_STAGES-2];
    end else begin : g_mul_direct
        assign mul_tap = mul_prod;
    end

    assign mul_res = (f3_q == 2'b00) ? mul_tap[XLEN-1:0] : mul_tap[2*XLEN-1:XLEN];

    // -------------------------------------------------------------------------
    // Restoring divide step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The partial remainder is
    // always below the divisor, so XLEN+1 bits cover the trial value.
    // -------------------------------------------------------------------------
    logic [XLEN:0]   div_trial;
    logic [XLEN:0]   div_sub;
    logic            div_bit;
    logic [XLEN-1:0] div_rem_d;
    logic [XLEN-1:0] div_quo_d;
    logic [XLEN-1:0] div_res;

    always_comb begin
        div_trial = {div_rem_q, div_quo_q[XLEN-1]};
        div_sub   = div_trial - {1'b0, div_dvs_q};
        div_bit   = ~div_sub[XLEN];
        div_rem_d = div_bit ? div_sub[XLEN-1:0] : div_trial[XLEN-1:0];
        div_quo_d = {div_quo_q[XLEN-2:0], div_bit};
        div_res   = f3_q[1] ? cond_neg(div_rem_d, neg_rem_q)
                            : cond_neg(div_quo_d, neg_quo_q);
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b1;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
        end else if (flush) begin
            // Beats both a simultaneous accept and a simultaneous grant.
            state_q     <= S_IDLE;
            rdy_q       <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mdu_packet.valid) begin
                        rdy_q     <= 1'b0;
                        f3_q      <= in_f3[1:0];
                        tag_q     <= mdu_packet.tag;
                        a_q       <= in_a;
                        b_q       <= in_b;
                        div_rem_q <= '0;
                        div_quo_q <= cond_neg(in_a, in_a_neg);
                        div_dvs_q <= cond_neg(in_b, in_b_neg);
                        neg_quo_q <= in_a_neg ^ in_b_neg;
                        neg_rem_q <= in_a_neg;
                        if (!in_f3[2]) begin
                            state_q <= S_MUL;
                            cnt_q   <= CNT_W'(MUL_STAGES - 1);
                        end else if (in_special) begin
                            state_q     <= S_DONE;
                            res_valid_q <= 1'b1;
                            res_tag_q   <= mdu_packet.tag;
                            res_data_q  <= in_special_res;
                        end else begin
                            state_q <= S_DIV;
                            cnt_q   <= CNT_W'(XLEN - 1);
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_DONE;
                        res_valid_q <= 1'b1;
                        res_tag_q   <= tag_q;
                        res_data_q  <= mul_res;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DIV: begin
                    div_rem_q <= div_rem_d;
                    div_quo_q <= div_quo_d;
                    if (cnt_q == '0) begin
                        state_q     <= S_DONE;
                        res_valid_q <= 1'b1;
                        res_tag_q   <= tag_q;
                        res_data_q  <= div_res;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    if (cdb_grant) begin
                        state_q     <= S_IDLE;
                        rdy_q       <= 1'b1;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rdy_q       <= 1'b1;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mdu_rdy = rdy_q;

    always_comb begin
        mdu_result       = '0;
        mdu_result.valid = res_valid_q;
        mdu_result.tag   = res_tag_q;
        mdu_result.data  = res_data_q;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// -----------------------------------------------------------------------------
// tb_mdu_unit: directed and randomized checks of mdu_unit against a plain
// arithmetic RV32M reference model (MUL_STAGES = 1).
// -----------------------------------------------------------------------------
module tb_mdu_unit;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic                       cdb_grant;
    logic                       mdu_rdy;
    mdu_pkg::instruction_t      pkt;
    mdu_pkg::writeback_packet_t res;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_unit #(.XLEN(32), .MUL_STAGES(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .mdu_packet (pkt),
        .mdu_rdy    (mdu_rdy),
        .mdu_result (res),
        .cdb_grant  (cdb_grant)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference result straight from the RV32M definitions.
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = ia / ib;
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = ia % ib;
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            4:       return -$urandom_range(1, 20);
            default: return $urandom();
        endcase
    endfunction

    // Present an op at a falling edge once the unit is ready; returns #1 after
    // the accepting rising edge with the packet withdrawn.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] tag);
        int w;
        w = 0;
        @(negedge clk);
        while (!mdu_rdy && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("rdy_before_issue", {63'd0, mdu_rdy}, 64'd1);
        pkt.valid  = 1'b1;
        pkt.funct3 = f3;
        pkt.rs1    = a;
        pkt.rs2    = b;
        pkt.tag    = tag;
        @(posedge clk);
        #1;
        pkt.valid = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] tag, input int hold);
        int          lat;
        logic [31:0] exp_d;
        exp_d = ref_res(f3, a, b);
        start_op(f3, a, b, tag);
        chk("rdy_busy", {63'd0, mdu_rdy}, 64'd0);
        lat = 1;
        while (!res.valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("latency f3=%0d a=%h b=%h", f3, a, b), 64'(lat), 64'(ref_lat(f3, a, b)));
        chk($sformatf("data f3=%0d a=%h b=%h", f3, a, b), {32'd0, res.data}, {32'd0, exp_d});
        chk("tag", {58'd0, res.tag}, {58'd0, tag});
        chk("rdy_while_done", {63'd0, mdu_rdy}, 64'd0);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        if (hold > 0) begin
            chk("hold_valid", {63'd0, res.valid}, 64'd1);
            chk("hold_data", {32'd0, res.data}, {32'd0, exp_d});
            chk("hold_tag", {58'd0, res.tag}, {58'd0, tag});
            chk("hold_rdy", {63'd0, mdu_rdy}, 64'd0);
        end
        @(negedge clk);
        cdb_grant = 1'b1;
        @(posedge clk);
        #1;
        cdb_grant = 1'b0;
        chk("grant_valid_clear", {63'd0, res.valid}, 64'd0);
        chk("grant_rdy", {63'd0, mdu_rdy}, 64'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        flush     = 1'b0;
        cdb_grant = 1'b0;
        pkt       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", {63'd0, mdu_rdy}, 64'd1);
        chk("reset_valid", {63'd0, res.valid}, 64'd0);
        chk("reset_tag", {58'd0, res.tag}, 64'd0);
        chk("reset_data", {32'd0, res.data}, 64'd0);
        rst = 1'b0;

        // Directed vectors
        run_op(3'd0, 32'hFFFF_FFFF, 32'h2, 6'd5, 0);
        run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd1, 0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 6'd2, 0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 6'd3, 0);
        run_op(3'd4, -32'sd7, 32'd2, 6'd7, 0);
        run_op(3'd6, -32'sd7, 32'd2, 6'd8, 0);
        run_op(3'd5, 32'd100, 32'd7, 6'd9, 0);
        run_op(3'd7, 32'd100, 32'd7, 6'd10, 0);
        run_op(3'd4, 32'd42, 32'd0, 6'd11, 0);
        run_op(3'd6, 32'd42, 32'd0, 6'd12, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'd13, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 6'd14, 0);

        // Long hold, then back-to-back op right after the grant
        run_op(3'd0, 32'h1234_5678, 32'h9, 6'd20, 10);
        run_op(3'd5, 32'hDEAD_BEEF, 32'h1_0001, 6'd21, 0);

        // Grant while nothing is held is ignored
        @(negedge clk);
        cdb_grant = 1'b1;
        @(posedge clk);
        #1;
        cdb_grant = 1'b0;
        chk("idle_grant_valid", {63'd0, res.valid}, 64'd0);
        chk("idle_grant_rdy", {63'd0, mdu_rdy}, 64'd1);

        // Flush mid-divide with a new packet presented on the same edge
        start_op(3'd4, 32'd1000, 32'd3, 6'd30);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush      = 1'b1;
        pkt.valid  = 1'b1;
        pkt.funct3 = 3'd5;
        pkt.rs1    = 32'd5;
        pkt.rs2    = 32'd0;
        pkt.tag    = 6'd31;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        pkt.valid = 1'b0;
        chk("flush_div_valid", {63'd0, res.valid}, 64'd0);
        chk("flush_div_rdy", {63'd0, mdu_rdy}, 64'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (res.valid) seen = 1;
        end
        chk("flush_div_no_result", 64'(seen), 64'd0);
        chk("flush_div_rdy_stays", {63'd0, mdu_rdy}, 64'd1);
        run_op(3'd4, 32'd1000, 32'd3, 6'd32, 0);

        // Flush beats an accept in IDLE (a divide-by-zero would show at once)
        @(negedge clk);
        flush      = 1'b1;
        pkt.valid  = 1'b1;
        pkt.funct3 = 3'd4;
        pkt.rs1    = 32'd9;
        pkt.rs2    = 32'd0;
        pkt.tag    = 6'd33;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        pkt.valid = 1'b0;
        chk("flush_accept_rdy", {63'd0, mdu_rdy}, 64'd1);
        chk("flush_accept_valid", {63'd0, res.valid}, 64'd0);

        // Flush beats a grant while a result is held
        start_op(3'd5, 32'd9, 32'd0, 6'd34);
        chk("special_valid", {63'd0, res.valid}, 64'd1);
        @(negedge clk);
        flush     = 1'b1;
        cdb_grant = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        cdb_grant = 1'b0;
        chk("flush_grant_valid", {63'd0, res.valid}, 64'd0);
        chk("flush_grant_rdy", {63'd0, mdu_rdy}, 64'd1);

        // Reset mid-divide
        start_op(3'd7, 32'hFFFF_0000, 32'd17, 6'd35);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_rdy", {63'd0, mdu_rdy}, 64'd1);
        chk("rst_mid_valid", {63'd0, res.valid}, 64'd0);
        chk("rst_mid_data", {32'd0, res.data}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (res.valid) seen = 1;
        end
        chk("rst_mid_no_result", 64'(seen), 64'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
                   6'($urandom_range(0, 63)), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
